// File: rtl/l2_cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_cache_pkg: shared line/address widths and controller state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package l2_cache_pkg;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESPOND = 2'd1,
    WB      = 2'd2,
    FETCH   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/l2_cache_way.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_cache_way: one way of tag/data/valid/dirty storage, async read, one write port
// Revision: 1.0
// ---------------------------------------------------------------------------
module l2_cache_way
  import l2_cache_pkg::*;
#(
  parameter int NUM_OF_SET = 16,
  parameter int SET_OFFSET = 4,
  parameter int TAG_W      = ADDR_W - SET_OFFSET
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [SET_OFFSET-1:0] idx_i,
  input  logic                  we_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [LINE_W-1:0]     data_i,
  input  logic                  dirty_i,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LINE_W-1:0]     data_o,
  output logic                  valid_o,
  output logic                  dirty_o
);

  logic [TAG_W-1:0]      tag_q   [NUM_OF_SET];
  logic [LINE_W-1:0]     data_q  [NUM_OF_SET];
  logic [NUM_OF_SET-1:0] valid_q;
  logic [NUM_OF_SET-1:0] dirty_q;

  // Every write leaves the entry valid; only reset invalidates.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_OF_SET; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      tag_q[idx_i]   <= tag_i;
      data_q[idx_i]  <= data_i;
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= dirty_i;
    end
  end

  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/l2_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_cache: 2-way set-associative write-back/write-allocate L2 with 1-bit LRU
// Revision: 1.0
// ---------------------------------------------------------------------------
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int NUM_OF_SET = 16,
  parameter int NUM_OF_WAY = 2,
  parameter int SET_OFFSET = 4
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [LINE_W-1:0] proc_wdata,
  output logic [LINE_W-1:0] proc_rdata,
  output logic              proc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - SET_OFFSET;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [LINE_W-1:0]     rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  victim_q, victim_d;
  logic [NUM_OF_SET-1:0] lru_q, lru_d;

  logic                  req_valid;
  logic [SET_OFFSET-1:0] live_set, req_set, idx;
  logic [TAG_W-1:0]      live_tag, req_tag;

  logic [TAG_W-1:0]      rd_tag  [NUM_OF_WAY];
  logic [LINE_W-1:0]     rd_data [NUM_OF_WAY];
  logic [NUM_OF_WAY-1:0] rd_valid, rd_dirty, hit, way_we;
  logic [TAG_W-1:0]      wr_tag;
  logic [LINE_W-1:0]     wr_data;
  logic                  wr_dirty;
  logic                  hit_way, live_victim;

  assign req_valid   = proc_read ^ proc_write;
  assign live_set    = proc_addr[SET_OFFSET-1:0];
  assign live_tag    = proc_addr[ADDR_W-1:SET_OFFSET];
  assign req_set     = addr_q[SET_OFFSET-1:0];
  assign req_tag     = addr_q[ADDR_W-1:SET_OFFSET];
  // Lookups use the live address in IDLE and the latched one everywhere else.
  assign idx         = (state_q == IDLE) ? live_set : req_set;
  assign hit_way     = hit[1];
  assign live_victim = lru_q[live_set];

  generate
    for (genvar w = 0; w < NUM_OF_WAY; w++) begin : g_way
      l2_cache_way #(
        .NUM_OF_SET(NUM_OF_SET),
        .SET_OFFSET(SET_OFFSET),
        .TAG_W     (TAG_W)
      ) u_way (
        .clk    (clk),
        .rst_i  (proc_reset),
        .idx_i  (idx),
        .we_i   (way_we[w]),
        .tag_i  (wr_tag),
        .data_i (wr_data),
        .dirty_i(wr_dirty),
        .tag_o  (rd_tag[w]),
        .data_o (rd_data[w]),
        .valid_o(rd_valid[w]),
        .dirty_o(rd_dirty[w])
      );
      assign hit[w] = rd_valid[w] && (rd_tag[w] == live_tag);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      write_q  <= write_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    write_d    = write_q;
    victim_d   = victim_q;
    lru_d      = lru_q;
    way_we     = '0;
    wr_tag     = '0;
    wr_data    = '0;
    wr_dirty   = 1'b0;
    proc_ready = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = proc_addr;
          wdata_d = proc_wdata;
          write_d = proc_write;
          rdata_d = '0;
          if (|hit) begin
            lru_d[live_set] = ~hit_way;
            if (proc_write) begin
              way_we[hit_way] = 1'b1;
              wr_tag          = live_tag;
              wr_data         = proc_wdata;
              wr_dirty        = 1'b1;
            end else begin
              rdata_d = rd_data[hit_way];
            end
            state_d = RESPOND;
          end else begin
            victim_d = live_victim;
            if (rd_valid[live_victim] && rd_dirty[live_victim]) begin
              state_d = WB;
            end else if (proc_write) begin
              // Full-line write: install directly, no fetch needed.
              way_we[live_victim] = 1'b1;
              wr_tag              = live_tag;
              wr_data             = proc_wdata;
              wr_dirty            = 1'b1;
              lru_d[live_set]     = ~live_victim;
              state_d             = RESPOND;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end

      WB: begin
        mem_write = 1'b1;
        mem_addr  = {rd_tag[victim_q], req_set};
        mem_wdata = rd_data[victim_q];
        if (mem_ready) begin
          way_we[victim_q] = 1'b1;
          if (write_q) begin
            wr_tag         = req_tag;
            wr_data        = wdata_q;
            wr_dirty       = 1'b1;
            lru_d[req_set] = ~victim_q;
            state_d        = RESPOND;
          end else begin
            wr_tag   = rd_tag[victim_q];
            wr_data  = rd_data[victim_q];
            wr_dirty = 1'b0;
            state_d  = FETCH;
          end
        end
      end

      FETCH: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        if (mem_ready) begin
          way_we[victim_q] = 1'b1;
          wr_tag           = req_tag;
          wr_data          = mem_rdata;
          wr_dirty         = 1'b0;
          lru_d[req_set]   = ~victim_q;
          rdata_d          = mem_rdata;
          state_d          = RESPOND;
        end
      end

      RESPOND: begin
        proc_ready = 1'b1;
        proc_rdata = rdata_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_l2_cache: directed self-checking bench for l2_cache (all traffic in set 0)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_l2_cache;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [27:0]  proc_addr;
  logic [127:0] proc_wdata;
  logic [127:0] proc_rdata;
  logic         proc_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_cache #(
    .NUM_OF_SET(16),
    .NUM_OF_WAY(2),
    .SET_OFFSET(4)
  ) dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .proc_read (proc_read),
    .proc_write(proc_write),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata),
    .proc_ready(proc_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  // Called in the RESPOND cycle: L1 holds one more edge, then drops.
  task automatic end_req();
    tick();
    issue(1'b0, 1'b0, 28'h0, 128'h0);
  endtask

  task automatic wait_mem(output bit got);
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      if (mem_read || mem_write) got = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    issue(1'b0, 1'b0, 28'h0, 128'h0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (3) tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ctrl: got %b expected 000", {proc_ready, mem_read, mem_write});
    end
    checks++;
    if (proc_rdata !== 128'h0 || mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
      failures++;
      $display("FAIL rst_data: got rdata=%0h addr=%0h wdata=%0h expected 0", proc_rdata, mem_addr, mem_wdata);
    end
    proc_reset = 1'b0;
    tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b000) begin
      failures++;
      $display("FAIL idle_ctrl: got %b expected 000", {proc_ready, mem_read, mem_write});
    end
  endtask

  task automatic test_read_miss();
    issue(1'b1, 1'b0, 28'h0000010, 128'h0);
    tick();
    checks++;
    if ({mem_read, mem_write, proc_ready} !== 3'b100 || mem_addr !== 28'h0000010) begin
      failures++;
      $display("FAIL miss_fetch: got rd/wr/rdy=%b addr=%0h expected 100 addr=10", {mem_read, mem_write, proc_ready}, mem_addr);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1 || proc_ready !== 1'b0) begin
      failures++;
      $display("FAIL miss_hold: got mem_read=%b proc_ready=%b expected 1 0", mem_read, proc_ready);
    end
    mem_ready = 1'b1;
    mem_rdata = 128'hA5;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checks++;
    if (proc_ready !== 1'b1 || proc_rdata !== 128'hA5 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL miss_resp: got rdy=%b rdata=%0h mem_read=%b expected 1 a5 0", proc_ready, proc_rdata, mem_read);
    end
    end_req();
    checks++;
    if (proc_ready !== 1'b0 || proc_rdata !== 128'h0) begin
      failures++;
      $display("FAIL miss_done: got rdy=%b rdata=%0h expected 0 0", proc_ready, proc_rdata);
    end
  endtask

  task automatic test_read_hit();
    issue(1'b1, 1'b0, 28'h0000010, 128'h0);
    tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b100 || proc_rdata !== 128'hA5) begin
      failures++;
      $display("FAIL hit_resp: got rdy/rd/wr=%b rdata=%0h expected 100 a5", {proc_ready, mem_read, mem_write}, proc_rdata);
    end
    end_req();
  endtask

  task automatic test_write_then_read();
    issue(1'b0, 1'b1, 28'h0000020, 128'hBEEF);
    tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b100 || proc_rdata !== 128'h0) begin
      failures++;
      $display("FAIL wmiss_clean: got rdy/rd/wr=%b rdata=%0h expected 100 0", {proc_ready, mem_read, mem_write}, proc_rdata);
    end
    tick();
    issue(1'b1, 1'b0, 28'h0000030, 128'h0);
    tick();
    checks++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000030) begin
      failures++;
      $display("FAIL clean_evict: got rd/wr=%b addr=%0h expected 10 addr=30", {mem_read, mem_write}, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 128'h30;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checks++;
    if (proc_ready !== 1'b1 || proc_rdata !== 128'h30) begin
      failures++;
      $display("FAIL clean_resp: got rdy=%b rdata=%0h expected 1 30", proc_ready, proc_rdata);
    end
    end_req();
  endtask

  task automatic test_dirty_read_miss();
    bit got;
    issue(1'b1, 1'b0, 28'h0000040, 128'h0);
    wait_mem(got);
    checks++;
    if (!got || {mem_write, mem_read} !== 2'b10 || mem_addr !== 28'h0000020 || mem_wdata !== 128'hBEEF) begin
      failures++;
      $display("FAIL wb_req: got seen=%0d wr/rd=%b addr=%0h wdata=%0h expected 1 10 20 beef", got, {mem_write, mem_read}, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({mem_write, mem_read, proc_ready} !== 3'b010 || mem_addr !== 28'h0000040) begin
      failures++;
      $display("FAIL wb_then_fetch: got wr/rd/rdy=%b addr=%0h expected 010 addr=40", {mem_write, mem_read, proc_ready}, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 128'h40;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checks++;
    if (proc_ready !== 1'b1 || proc_rdata !== 128'h40 || {mem_read, mem_write} !== 2'b00) begin
      failures++;
      $display("FAIL dirty_resp: got rdy=%b rdata=%0h rd/wr=%b expected 1 40 00", proc_ready, proc_rdata, {mem_read, mem_write});
    end
    end_req();
  endtask

  task automatic test_both_high();
    issue(1'b1, 1'b1, 28'h0000050, 128'h1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({proc_ready, mem_read, mem_write} !== 3'b000) begin
        failures++;
        $display("FAIL both_high_%0d: got rdy/rd/wr=%b expected 000", i, {proc_ready, mem_read, mem_write});
      end
    end
    issue(1'b1, 1'b0, 28'h0000030, 128'h0);
    tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b100 || proc_rdata !== 128'h30) begin
      failures++;
      $display("FAIL both_high_nochg: got rdy/rd/wr=%b rdata=%0h expected 100 30", {proc_ready, mem_read, mem_write}, proc_rdata);
    end
    end_req();
  endtask

  task automatic test_reset_mid_fetch();
    issue(1'b1, 1'b0, 28'h0000050, 128'h0);
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000050) begin
      failures++;
      $display("FAIL rstf_fetch: got mem_read=%b addr=%0h expected 1 50", mem_read, mem_addr);
    end
    proc_reset = 1'b1;
    issue(1'b0, 1'b0, 28'h0, 128'h0);
    tick();
    checks++;
    if ({mem_read, mem_write, proc_ready} !== 3'b000) begin
      failures++;
      $display("FAIL rstf_abandon: got rd/wr/rdy=%b expected 000", {mem_read, mem_write, proc_ready});
    end
    proc_reset = 1'b0;
    tick();
    // 0x30 hit before the reset; it must now miss.
    issue(1'b1, 1'b0, 28'h0000030, 128'h0);
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000030 || proc_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstf_flush: got mem_read=%b addr=%0h rdy=%b expected 1 30 0", mem_read, mem_addr, proc_ready);
    end
    mem_ready = 1'b1;
    mem_rdata = 128'h3030;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    end_req();
    issue(1'b1, 1'b0, 28'h0000010, 128'h0);
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin
      failures++;
      $display("FAIL rstf_refetch: got mem_read=%b addr=%0h expected 1 10", mem_read, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 128'h77;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checks++;
    if (proc_ready !== 1'b1 || proc_rdata !== 128'h77) begin
      failures++;
      $display("FAIL rstf_resp: got rdy=%b rdata=%0h expected 1 77", proc_ready, proc_rdata);
    end
    end_req();
  endtask

  // Set 0 now: way0=0x30 clean, way1=0x10 clean, lru=0.
  task automatic test_dirty_write_miss();
    bit got;
    issue(1'b0, 1'b1, 28'h0000020, 128'hBEEF);
    tick();
    end_req();
    issue(1'b0, 1'b1, 28'h0000040, 128'h44);
    tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b100) begin
      failures++;
      $display("FAIL wmiss2: got rdy/rd/wr=%b expected 100", {proc_ready, mem_read, mem_write});
    end
    end_req();
    issue(1'b0, 1'b1, 28'h0000050, 128'h55);
    wait_mem(got);
    checks++;
    if (!got || {mem_write, mem_read} !== 2'b10 || mem_addr !== 28'h0000020 || mem_wdata !== 128'hBEEF) begin
      failures++;
      $display("FAIL wdirty_wb: got seen=%0d wr/rd=%b addr=%0h wdata=%0h expected 1 10 20 beef", got, {mem_write, mem_read}, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b100 || proc_rdata !== 128'h0) begin
      failures++;
      $display("FAIL wdirty_resp: got rdy/rd/wr=%b rdata=%0h expected 100 0", {proc_ready, mem_read, mem_write}, proc_rdata);
    end
    end_req();
    issue(1'b0, 1'b1, 28'h0000040, 128'h99);
    tick();
    checks++;
    if ({proc_ready, mem_read, mem_write} !== 3'b100) begin
      failures++;
      $display("FAIL whit: got rdy/rd/wr=%b expected 100", {proc_ready, mem_read, mem_write});
    end
    end_req();
    issue(1'b1, 1'b0, 28'h0000040, 128'h0);
    tick();
    checks++;
    if (proc_ready !== 1'b1 || proc_rdata !== 128'h99 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL whit_read: got rdy=%b rdata=%0h mem_read=%b expected 1 99 0", proc_ready, proc_rdata, mem_read);
    end
    end_req();
    issue(1'b1, 1'b0, 28'h0000050, 128'h0);
    tick();
    checks++;
    if (proc_ready !== 1'b1 || proc_rdata !== 128'h55 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL winst_read: got rdy=%b rdata=%0h mem_read=%b expected 1 55 0", proc_ready, proc_rdata, mem_read);
    end
    end_req();
  endtask

  initial begin
    proc_reset = 1'b1;
    issue(1'b0, 1'b0, 28'h0, 128'h0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_then_read();
    test_dirty_read_miss();
    test_both_high();
    test_reset_mid_fetch();
    test_dirty_write_miss();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
